// File: rtl/conv_result_buffer.sv
// Captures one conv-engine feature map into a local RAM, then replays it in
// row-major order as a contiguous pixel stream for the next layer's line buffer.
module conv_result_buffer #(
  parameter int DW    = 16,
  parameter int DEPTH = 576,
  parameter int AW    = 10,
  parameter int N0    = 576,
  parameter int N1    = 64
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          state,
  input  logic [DW-1:0] din,
  input  logic          ivalid,
  input  logic          idone,
  output logic          ostart,
  output logic [DW-1:0] dout,
  output logic          ovalid,
  output logic          olast,
  output logic          done,
  output logic          busy,
  output logic          err
);

  typedef enum logic [1:0] {IDLE, CAPTURE, REPLAY, FLUSH} fsm_t;

  // Counts are one bit wider than addresses so a full buffer (cnt==DEPTH) is representable.
  localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   N0_W     = (AW+1)'(N0);
  localparam logic [AW:0]   N1_W     = (AW+1)'(N1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] ADDR_ONE = AW'(1);

  fsm_t          cur, nxt;
  logic [AW:0]   cnt, cnt_nxt;
  logic [AW:0]   len, len_nxt;
  logic [AW:0]   last_addr;
  logic [AW-1:0] rd_addr, rd_addr_nxt;
  logic          err_nxt;
  logic          flush_done, flush_done_nxt;
  logic          at_last;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] ram_q;

  assign last_addr = len - CNT_ONE;
  assign at_last   = ({1'b0, rd_addr} == last_addr);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cur <= IDLE;
    else       cur <= nxt;
  end

  always_comb begin
    nxt            = cur;
    cnt_nxt        = cnt;
    len_nxt        = len;
    rd_addr_nxt    = rd_addr;
    err_nxt        = err;
    flush_done_nxt = 1'b0;
    wr_en          = 1'b0;
    wr_addr        = cnt[AW-1:0];
    case (cur)
      IDLE: begin
        if (ivalid) begin
          wr_en       = 1'b1;
          wr_addr     = '0;
          cnt_nxt     = CNT_ONE;
          len_nxt     = state ? N1_W : N0_W;
          err_nxt     = 1'b0;
          rd_addr_nxt = '0;
          if (idone) begin
            nxt     = REPLAY;
            err_nxt = 1'b1;
          end else begin
            nxt = CAPTURE;
          end
        end
      end
      CAPTURE: begin
        if (ivalid) begin
          if (cnt < DEPTH_W) begin
            wr_en   = 1'b1;
            cnt_nxt = cnt + CNT_ONE;
          end else begin
            err_nxt = 1'b1;
          end
          if (idone) begin
            nxt         = REPLAY;
            rd_addr_nxt = '0;
            if (cnt_nxt != len) err_nxt = 1'b1;
          end
        end
      end
      REPLAY: begin
        if (ivalid) err_nxt = 1'b1;
        rd_addr_nxt = rd_addr + ADDR_ONE;
        if (at_last) nxt = FLUSH;
      end
      FLUSH: begin
        // Second FLUSH cycle is the done cycle; input there belongs to no map and is dropped silently.
        if (!flush_done) begin
          flush_done_nxt = 1'b1;
          if (ivalid) err_nxt = 1'b1;
        end else begin
          nxt = IDLE;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt        <= '0;
      len        <= '0;
      rd_addr    <= '0;
      err        <= 1'b0;
      flush_done <= 1'b0;
      ovalid     <= 1'b0;
      olast      <= 1'b0;
      ostart     <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      len        <= len_nxt;
      rd_addr    <= rd_addr_nxt;
      err        <= err_nxt;
      flush_done <= flush_done_nxt;
      ovalid     <= (cur == REPLAY);
      olast      <= (cur == REPLAY) && at_last;
      if (cur == REPLAY)                 ostart <= 1'b1;
      else if (cur == FLUSH && flush_done) ostart <= 1'b0;
    end
  end

  // Plain synchronous RAM; contents survive reset and short maps replay stale words.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= din;
    ram_q <= mem[rd_addr];
  end

  assign dout = ovalid ? ram_q : '0;
  assign done = (cur == FLUSH) && flush_done;
  assign busy = (cur != IDLE);

endmodule

// File: tb/tb_conv_result_buffer.sv
// Directed bench for conv_result_buffer: a reference memory model feeds a
// scoreboard queue of expected replay words that is drained as beats appear.
module tb_conv_result_buffer;

  logic        clk;
  logic        rstn;
  logic        state;
  logic [15:0] din;
  logic        ivalid;
  logic        idone;
  logic        ostart;
  logic [15:0] dout;
  logic        ovalid;
  logic        olast;
  logic        done;
  logic        busy;
  logic        err;

  int          n_assert;
  int          n_fail;
  logic [15:0] mdl [576];
  logic [15:0] sb [$];

  conv_result_buffer dut (
    .clk    (clk),
    .rstn   (rstn),
    .state  (state),
    .din    (din),
    .ivalid (ivalid),
    .idone  (idone),
    .ostart (ostart),
    .dout   (dout),
    .ovalid (ovalid),
    .olast  (olast),
    .done   (done),
    .busy   (busy),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic d, input logic [15:0] w, input logic st);
    ivalid = v;
    idone  = d;
    din    = w;
    state  = st;
    @(posedge clk);
    #1;
    ivalid = 1'b0;
    idone  = 1'b0;
  endtask

  // Sends n words (idone on the last), updates the model and fills the scoreboard.
  // state flips after the first word to show the map size is latched at capture start.
  task automatic send_map(input logic st, input int n, input int base, input logic neg,
                          input logic bubbles, output logic exp_err);
    int          cnt;
    int          len;
    logic [15:0] w;
    cnt = 0;
    len = st ? 64 : 576;
    for (int i = 0; i < n; i++) begin
      if (bubbles && i > 0) begin
        int nb;
        nb = $urandom_range(0, 2);
        for (int b = 0; b < nb; b++) drive(1'b0, 1'($urandom_range(0, 1)), 16'($urandom), ~st);
      end
      w = neg ? 16'(-i) : 16'(base + i);
      if (cnt < 576) begin
        mdl[cnt] = w;
        cnt++;
      end
      drive(1'b1, (i == n - 1), w, (i == 0) ? st : ~st);
      if (i == 0) begin
        check1("err_clear_at_start", err, (n == 1));
        check1("busy_after_first", busy, 1'b1);
      end
    end
    for (int j = 0; j < len; j++) sb.push_back(mdl[j]);
    exp_err = (n > 576) || (cnt != len);
  endtask

  // Called right after the idone edge; checks latency, every beat, olast, done and cleanup.
  task automatic run_replay(input int len, input logic exp_err, input int inject_at,
                            input int reset_at, input logic b2b);
    logic [15:0] e;
    @(negedge clk);
    check1("pre_ovalid", ovalid, 1'b0);
    check1("pre_busy", busy, 1'b1);
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      ivalid = 1'b0;
      check1("sb_nonempty", (sb.size() > 0), 1'b1);
      e = (sb.size() > 0) ? sb.pop_front() : 16'hxxxx;
      check1("ovalid", ovalid, 1'b1);
      check16("dout", dout, e);
      check1("olast", olast, (k == len - 1));
      check1("ostart", ostart, 1'b1);
      check1("done_early", done, 1'b0);
      if (k == inject_at) begin
        ivalid = 1'b1;
        din    = 16'h5a5a;
      end
      if (k == reset_at) begin
        rstn = 1'b0;
        #1;
        check1("rst_ovalid", ovalid, 1'b0);
        check16("rst_dout", dout, 16'h0000);
        check1("rst_ostart", ostart, 1'b0);
        check1("rst_olast", olast, 1'b0);
        check1("rst_done", done, 1'b0);
        check1("rst_busy", busy, 1'b0);
        check1("rst_err", err, 1'b0);
        sb.delete();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check1("post_rst_busy", busy, 1'b0);
        return;
      end
    end
    @(negedge clk);
    check1("done", done, 1'b1);
    check1("done_ovalid", ovalid, 1'b0);
    check1("done_olast", olast, 1'b0);
    check1("done_err", err, exp_err);
    if (b2b) begin
      ivalid = 1'b1;
      din    = 16'h7777;
      state  = 1'b1;
    end
    @(negedge clk);
    ivalid = 1'b0;
    check1("after_done", done, 1'b0);
    check1("after_busy", busy, 1'b0);
    check1("after_ostart", ostart, 1'b0);
    check1("after_ovalid", ovalid, 1'b0);
  endtask

  initial begin
    logic ee;
    n_assert = 0;
    n_fail   = 0;
    rstn     = 1'b0;
    state    = 1'b0;
    din      = '0;
    ivalid   = 1'b0;
    idone    = 1'b0;
    repeat (3) @(negedge clk);
    check1("reset_ostart", ostart, 1'b0);
    check16("reset_dout", dout, 16'h0000);
    check1("reset_ovalid", ovalid, 1'b0);
    check1("reset_olast", olast, 1'b0);
    check1("reset_done", done, 1'b0);
    check1("reset_busy", busy, 1'b0);
    check1("reset_err", err, 1'b0);
    rstn = 1'b1;
    @(negedge clk);

    $display("[TB] full 24x24 map");
    send_map(1'b0, 576, 0, 1'b0, 1'b0, ee);
    run_replay(576, ee, -1, -1, 1'b0);

    $display("[TB] 8x8 map, negative words, bubbles");
    send_map(1'b1, 64, 0, 1'b1, 1'b1, ee);
    run_replay(64, ee, -1, -1, 1'b0);

    $display("[TB] short 8x8 map of 40 words");
    send_map(1'b1, 40, 100, 1'b0, 1'b0, ee);
    run_replay(64, ee, -1, -1, 1'b0);

    $display("[TB] overflowing 24x24 map of 580 words");
    send_map(1'b0, 580, 1000, 1'b0, 1'b0, ee);
    run_replay(576, ee, -1, -1, 1'b0);

    $display("[TB] reset during replay");
    send_map(1'b0, 576, 3000, 1'b0, 1'b0, ee);
    run_replay(576, ee, -1, 100, 1'b0);
    send_map(1'b1, 64, 2000, 1'b0, 1'b0, ee);
    run_replay(64, ee, -1, -1, 1'b0);

    $display("[TB] ivalid during replay, then input on the done cycle");
    send_map(1'b1, 64, 4000, 1'b0, 1'b0, ee);
    run_replay(64, 1'b1, 10, -1, 1'b1);

    $display("[TB] clean map clears err");
    send_map(1'b1, 64, 5000, 1'b0, 1'b1, ee);
    run_replay(64, ee, -1, -1, 1'b0);

    $display("[TB] single-word map");
    send_map(1'b1, 1, 6000, 1'b0, 1'b0, ee);
    run_replay(64, ee, -1, -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
